ram_arbiter: RTL and testbench

- Multicore RAM arbiter and sequencer. Shares the single RAM port between 2*CPUS cache requesters (one icache and one dcache per core).
- Grants one requester at a time using round-robin, holds the RAM request until RAM reports ACCESS, then completes the grant by dropping that requester's wait.
- Sits between the per-core cache controllers and the RAM model. Replaces the fixed-priority, single-core steering.

---
 rtl/ram_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sequencer sharing one RAM port between 2*CPUS
// cache requesters. Requester r = 2*c is dcache c and r = 2*c+1 is icache c.
// A grant is registered in IDLE. The granted request is driven onto the RAM
// in BUSY until the RAM answers ACCESS. In that cycle the requester's wait
// drops combinationally.
//
// Optional build macro: ARB_TIMEOUT_EN adds the TIMEOUT parameter, a BUSY
// cycle counter and the sticky arb_timeout output.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   iREN/iaddr        icache read request / address per core
//   dREN/dWEN/daddr/  dcache read, write request, address and write data
//   dstore              per core
//   iwait/dwait       per-core waits (1 = not done)
//   iload/dload       per-core read data (ramload for the granted cache)
//   ramaddr/ramstore/ RAM request driven from the granted requester
//   ramREN/ramWEN
//   ramstate/ramload  RAM status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR) and data
//   ram_err           sticky flag, set when ERROR is seen
//   arb_timeout       (ARB_TIMEOUT_EN only) sticky flag, set on a timeout abort
module ram_arbiter #(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned WORD_W  = 32
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  logic [1:0]               ramstate,
  input  logic [WORD_W-1:0]        ramload,
  output logic                     ram_err
`ifdef ARB_TIMEOUT_EN
  , output logic                   arb_timeout
`endif
);

  localparam int unsigned NREQ = 2 * CPUS;
  localparam int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CIW  = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNTW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt;
  logic [GW-1:0]   r_rr_ptr, w_rr_nxt;
  logic            r_err, w_err_nxt;

`ifdef ARB_TIMEOUT_EN
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
`endif

  logic [NREQ-1:0] w_req;
  logic            w_found;
  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_idx;
  logic [CIW-1:0]  w_core;
  int unsigned     w_base;
  logic            w_is_d;
  logic            w_greq;
  logic [GW-1:0]   w_grant_inc;

  // Request vector: even slots are dcache, odd slots are icache.
  always_comb begin
    w_req = '0;
    for (int unsigned c = 0; c < CPUS; c++) begin
      w_req[2*c]   = dREN[c] | dWEN[c];
      w_req[2*c+1] = iREN[c];
    end
  end

  // First set requester at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = GW'((32'(r_rr_ptr) + k) % NREQ);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Decode of the current grant.
  always_comb begin
    w_core      = CIW'(r_grant >> 1);
    w_base      = 32'(w_core) * WORD_W;
    w_is_d      = ~r_grant[0];
    w_greq      = w_req[r_grant];
    w_grant_inc = (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
  end

  // Next-state, RAM steering and per-requester completion.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_err_nxt   = r_err;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_win;
          w_state_nxt = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end

      ST_BUSY: begin
        if (w_is_d) begin
          ramaddr  = daddr[w_base +: WORD_W];
          ramstore = dstore[w_base +: WORD_W];
          ramWEN   = dWEN[w_core];
          // A write wins when both enables are set.
          ramREN   = dREN[w_core] & ~dWEN[w_core];
          dload[w_base +: WORD_W] = ramload;
        end else begin
          ramaddr  = iaddr[w_base +: WORD_W];
          ramREN   = 1'b1;
          iload[w_base +: WORD_W] = ramload;
        end

        if (!w_greq) begin
          // Requester gave up: abort without completion, keep rr_ptr.
          w_state_nxt = ST_IDLE;
        end else if (ramstate == RS_ACCESS) begin
          if (w_is_d) dwait[w_core] = 1'b0;
          else        iwait[w_core] = 1'b0;
          w_rr_nxt    = w_grant_inc;
          w_state_nxt = ST_IDLE;
        end else begin
          if (ramstate == RS_ERROR) w_err_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt = r_cnt + 1'b1;
          // This cycle completes TIMEOUT BUSY cycles without ACCESS.
          if (r_cnt == CNTW'(TIMEOUT - 1)) begin
            w_timeout_nxt = 1'b1;
            w_rr_nxt      = w_grant_inc;
            w_state_nxt   = ST_IDLE;
          end
`endif
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_err    <= w_err_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  assign ram_err = r_err;
`ifdef ARB_TIMEOUT_EN
  assign arb_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter (default build, CPUS=2, WORD_W=32).
// Directed scenarios followed by random traffic. Everything is checked
// against a transaction-level model of the arbiter kept in this file.
module tb_ram_arbiter;
  localparam int CPUS = 2;
  localparam int W    = 32;
  localparam int N    = 2 * CPUS;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    iREN, dREN, dWEN;
  logic [63:0]   iaddr, daddr, dstore;
  logic [1:0]    iwait, dwait;
  logic [63:0]   iload, dload;
  logic [31:0]   ramaddr, ramstore, ramload;
  logic          ramREN, ramWEN, ram_err;
  logic [1:0]    ramstate;

  int total = 0;
  int bad   = 0;

  // Model: whether a transaction is in flight, who owns it, where the
  // round-robin scan starts, and the sticky error flag.
  int   m_busy, m_grant, m_ptr;
  logic m_err;

  // Values observed in the most recent step.
  logic        s_ren, s_wen, s_err;
  logic [31:0] s_addr, s_store;
  logic [1:0]  s_iwait, s_dwait;
  logic [63:0] s_iload;
  int          s_done;

  ram_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstate(ramstate), .ramload(ramload), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic req_of(input int r);
    return (r % 2 == 0) ? (dREN[r/2] | dWEN[r/2]) : iREN[r/2];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_ptr = 0; m_err = 1'b0;
  endtask

  // Called right after inputs change on a falling edge: check outputs,
  // advance the model across the next rising edge, return at the next falling edge.
  task automatic step(input string tag);
    logic        e_ren, e_wen, greq, found;
    logic [31:0] e_addr, e_store;
    logic [1:0]  e_iw, e_dw;
    logic [63:0] e_il, e_dl;
    int c;
    #1;
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    e_iw = 2'b11; e_dw = 2'b11; e_il = 0; e_dl = 0; greq = 0;
    if (m_busy != 0) begin
      c    = m_grant / 2;
      greq = req_of(m_grant);
      if (m_grant % 2 == 0) begin
        e_addr  = daddr[c*W +: W];
        e_store = dstore[c*W +: W];
        e_wen   = dWEN[c];
        e_ren   = dREN[c] & ~dWEN[c];
        e_dl[c*W +: W] = ramload;
        if (greq && ramstate == 2'd2) e_dw[c] = 1'b0;
      end else begin
        e_addr = iaddr[c*W +: W];
        e_ren  = 1'b1;
        e_il[c*W +: W] = ramload;
        if (greq && ramstate == 2'd2) e_iw[c] = 1'b0;
      end
    end

    s_ren = ramREN; s_wen = ramWEN; s_err = ram_err; s_addr = ramaddr;
    s_store = ramstore; s_iwait = iwait; s_dwait = dwait; s_iload = iload;
    s_done = -1;
    for (int r = 0; r < N; r++)
      if (((r % 2 == 0) ? dwait[r/2] : iwait[r/2]) == 1'b0) s_done = r;

    chk({tag, "/ramREN"},   64'(ramREN),   64'(e_ren));
    chk({tag, "/ramWEN"},   64'(ramWEN),   64'(e_wen));
    chk({tag, "/ramaddr"},  64'(ramaddr),  64'(e_addr));
    chk({tag, "/ramstore"}, 64'(ramstore), 64'(e_store));
    chk({tag, "/iwait"},    64'(iwait),    64'(e_iw));
    chk({tag, "/dwait"},    64'(dwait),    64'(e_dw));
    chk({tag, "/iload"},    iload,         e_il);
    chk({tag, "/dload"},    dload,         e_dl);
    chk({tag, "/ram_err"},  64'(ram_err),  64'(m_err));

    if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_of((m_ptr + k) % N)) begin
          found = 1; m_busy = 1; m_grant = (m_ptr + k) % N;
        end
      end
    end else if (!greq) begin
      m_busy = 0;
    end else if (ramstate == 2'd2) begin
      m_busy = 0;
      m_ptr  = (m_grant + 1) % N;
    end else if (ramstate == 2'd3) begin
      m_err = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [1:0] rs;
    int pick;

    RST = 1'b1;
    idle_inputs();
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    model_reset();
    @(negedge CLK);
    #1;
    chk("rst/ramREN",  64'(ramREN),  64'd0);
    chk("rst/ramWEN",  64'(ramWEN),  64'd0);
    chk("rst/ramaddr", 64'(ramaddr), 64'd0);
    chk("rst/iwait",   64'(iwait),   64'd3);
    chk("rst/dwait",   64'(dwait),   64'd3);
    chk("rst/ram_err", 64'(ram_err), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // All four requesters held, RAM always ready: strict rotation, one idle gap.
    dREN = 2'b11; iREN = 2'b11; ramstate = 2'd2; ramload = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      step("rr");
      chk("rr/done", 64'(s_done), (i % 2 == 1) ? 64'(order[i/2]) : 64'(-1));
    end
    idle_inputs();
    step("rr_idle");

    // Single icache read, RAM answers after three enabled cycles.
    iREN[0] = 1'b1; iaddr[31:0] = 32'h100;
    step("ird_grant");
    ramstate = 2'd1;
    for (int i = 0; i < 2; i++) begin
      step("ird_busy");
      chk("ird_busy/ren",   64'(s_ren),   64'd1);
      chk("ird_busy/addr",  64'(s_addr),  64'h100);
      chk("ird_busy/iwait", 64'(s_iwait), 64'd3);
    end
    ramstate = 2'd2; ramload = 32'hCAFE_0001;
    step("ird_acc");
    chk("ird_acc/addr",  64'(s_addr),     64'h100);
    chk("ird_acc/iwait", 64'(s_iwait),    64'b10);
    chk("ird_acc/iload", s_iload & 64'hFFFF_FFFF, 64'hCAFE_0001);
    idle_inputs();
    step("ird_idle");

    // dcache 1 with both read and write set: write wins.
    dREN[1] = 1'b1; dWEN[1] = 1'b1; daddr[63:32] = 32'h40; dstore[63:32] = 32'hDEAD_BEEF;
    step("dwr_grant");
    ramstate = 2'd2;
    step("dwr_acc");
    chk("dwr/wen",   64'(s_wen),   64'd1);
    chk("dwr/ren",   64'(s_ren),   64'd0);
    chk("dwr/store", 64'(s_store), 64'hDEAD_BEEF);
    chk("dwr/addr",  64'(s_addr),  64'h40);
    chk("dwr/dwait", 64'(s_dwait), 64'b01);
    idle_inputs();
    step("dwr_idle");

    // icache 1 granted then withdrawn; scan restarts at r3 and finds r1.
    iREN[1] = 1'b1; ramstate = 2'd1;
    step("abt_grant");
    step("abt_busy");
    chk("abt_busy/ren", 64'(s_ren), 64'd1);
    iREN[1] = 1'b0; iREN[0] = 1'b1; dREN[1] = 1'b1;
    step("abt_drop");
    chk("abt_drop/iwait", 64'(s_iwait), 64'd3);
    step("abt_regrant");
    ramstate = 2'd2;
    step("abt_acc");
    chk("abt_acc/done", 64'(s_done), 64'd1);
    idle_inputs();
    step("abt_idle");
    step("abt_idle2");

    // ERROR twice then ACCESS: sticky ram_err, completion on ACCESS.
    dREN[0] = 1'b1; ramstate = 2'd1;
    step("err_grant");
    ramstate = 2'd3;
    step("err_1");
    step("err_2");
    chk("err_2/ram_err", 64'(s_err), 64'd1);
    ramstate = 2'd2;
    step("err_acc");
    chk("err_acc/dwait", 64'(s_dwait), 64'b10);
    idle_inputs();
    step("err_idle");
    chk("err_idle/ram_err", 64'(s_err), 64'd1);

    // Reset while BUSY: enables drop without waiting for a clock edge.
    iREN[0] = 1'b1; ramstate = 2'd1;
    step("rb_grant");
    step("rb_busy");
    chk("rb_busy/ren", 64'(s_ren), 64'd1);
    RST = 1'b1;
    #1;
    chk("rb_rst/ramREN",  64'(ramREN),  64'd0);
    chk("rb_rst/iwait",   64'(iwait),   64'd3);
    chk("rb_rst/ram_err", 64'(ram_err), 64'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    step("rb_idle");

    // Random traffic with sticky-ish requests.
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 3) == 0) iREN[b] = ~iREN[b];
        if ($urandom_range(0, 3) == 0) dREN[b] = ~dREN[b];
        if ($urandom_range(0, 5) == 0) dWEN[b] = ~dWEN[b];
      end
      iaddr  = {$urandom, $urandom};
      daddr  = {$urandom, $urandom};
      dstore = {$urandom, $urandom};
      ramload = $urandom;
      pick = $urandom_range(0, 9);
      rs = (pick < 2) ? 2'd0 : (pick < 5) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
      ramstate = rs;
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
